// File: rtl/audio_attenuator_pkg.sv
// Shared audio types: gain selectors, unity gain, stereo sample and 25->16 bit saturation.
package audiotypes;

  typedef enum logic [1:0] {
    kLL = 2'd0,
    kLR = 2'd1,
    kRL = 2'd2,
    kRR = 2'd3
  } att_sel_e;

  localparam logic [7:0] kUnityGain = 8'h80;
  localparam int         NUM_GAINS  = 4;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } stereo_t;

  // Drops the Q1.7 fraction, then clamps to the 16-bit sample range.
  function automatic logic signed [15:0] sat16(input logic signed [24:0] acc);
    logic signed [24:0] sh;
    sh = acc >>> 7;
    if (sh > 25'sd32767)       return 16'sh7FFF;
    else if (sh < -25'sd32768) return 16'sh8000;
    else                       return sh[15:0];
  endfunction

endpackage

// File: rtl/audio_attenuator_gain_ramp.sv
// One gain channel: clamped target register plus a current gain that slews one LSB per step.
module gain_ramp
  import audiotypes::*;
#(
  parameter logic [7:0] RST_GAIN = kUnityGain
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_i,
  input  logic [7:0] val_i,
  input  logic       mute_i,
  input  logic       step_i,
  output logic [7:0] gain_o
);

  logic [7:0] tgt_q, cur_q, cur_d, eff;

  assign eff    = mute_i ? 8'h00 : tgt_q;
  assign gain_o = cur_q;

  always_comb begin
    cur_d = cur_q;
    if (step_i) begin
      if (cur_q < eff)      cur_d = cur_q + 8'd1;
      else if (cur_q > eff) cur_d = cur_q - 8'd1;
    end
  end

  // The step reads the pre-write target, so a write landing with a step takes effect next step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_q <= RST_GAIN;
      cur_q <= RST_GAIN;
    end else begin
      if (wr_i) tgt_q <= (val_i > kUnityGain) ? kUnityGain : val_i;
      cur_q <= cur_d;
    end
  end

endmodule

// File: rtl/audio_attenuator.sv
// Stereo 2x2 gain matrix with ramped gains, sharing one multiplier across four cycles per sample.
module audio_attenuator
  import audiotypes::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_strobe,
  input  logic signed [15:0] in_left,
  input  logic signed [15:0] in_right,
  input  logic               att_write,
  input  logic [1:0]         att_sel,
  input  logic [7:0]         att_value,
  input  logic               mute,
  output logic signed [15:0] out_left,
  output logic signed [15:0] out_right,
  output logic               out_valid,
  output logic               overrun
);

  localparam logic [2:0] IDLE = 3'd0, M0 = 3'd1, M1 = 3'd2, M2 = 3'd3, M3 = 3'd4, OUT = 3'd5;

  logic [2:0]                       state_q, state_d;
  stereo_t                          work_q, pend_q, in_s;
  logic                             pend_vld_q;
  logic signed [24:0]               acc_l_q, acc_r_q, prod;
  logic signed [15:0]               mul_a;
  logic [7:0]                       mul_g;
  logic [NUM_GAINS-1:0][7:0]        gain;
  logic signed [15:0]               out_l_q, out_r_q;
  logic                             out_vld_q, ovr_q;

  assign in_s      = '{l: in_left, r: in_right};
  assign out_left  = out_l_q;
  assign out_right = out_r_q;
  assign out_valid = out_vld_q;
  assign overrun   = ovr_q;

  for (genvar i = 0; i < NUM_GAINS; i++) begin : g_ramp
    gain_ramp #(
      .RST_GAIN((i == int'(kLL) || i == int'(kRR)) ? kUnityGain : 8'h00)
    ) u_ramp (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_i    (att_write && (att_sel == 2'(i))),
      .val_i   (att_value),
      .mute_i  (mute),
      .step_i  (state_q == OUT),
      .gain_o  (gain[i])
    );
  end

  // Single shared multiplier; operand pair selected by the sequencing state.
  always_comb begin
    mul_a = work_q.l;
    mul_g = gain[kLL];
    case (state_q)
      M1:      begin mul_a = work_q.r; mul_g = gain[kRL]; end
      M2:      begin mul_a = work_q.l; mul_g = gain[kLR]; end
      M3:      begin mul_a = work_q.r; mul_g = gain[kRR]; end
      default: begin mul_a = work_q.l; mul_g = gain[kLL]; end
    endcase
    prod = 25'(mul_a) * 25'($signed({1'b0, mul_g}));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_strobe || pend_vld_q) state_d = M0;
      M0:      state_d = M1;
      M1:      state_d = M2;
      M2:      state_d = M3;
      M3:      state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      out_l_q    <= '0;
      out_r_q    <= '0;
      out_vld_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_vld_q <= (state_q == OUT);
      // Starting from IDLE frees the pending slot, so a same-cycle strobe can refill it.
      if (state_q == IDLE) begin
        if (pend_vld_q) begin
          work_q <= pend_q;
          if (sample_strobe) pend_q <= in_s;
          else               pend_vld_q <= 1'b0;
        end else if (sample_strobe) begin
          work_q <= in_s;
        end
      end else if (sample_strobe) begin
        if (!pend_vld_q) begin
          pend_q     <= in_s;
          pend_vld_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
      case (state_q)
        M0:  acc_l_q <= prod;
        M1:  acc_l_q <= acc_l_q + prod;
        M2:  acc_r_q <= prod;
        M3:  acc_r_q <= acc_r_q + prod;
        OUT: begin
          out_l_q <= sat16(acc_l_q);
          out_r_q <= sat16(acc_r_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_attenuator.sv
// Randomized bench for audio_attenuator against a per-sample arithmetic reference model.
module tb_audio_attenuator;

  logic               clk, reset_n, sample_strobe, att_write, mute;
  logic signed [15:0] in_left, in_right, out_left, out_right;
  logic [1:0]         att_sel;
  logic [7:0]         att_value;
  logic               out_valid, overrun;

  audio_attenuator dut (
    .clk(clk), .reset_n(reset_n), .sample_strobe(sample_strobe),
    .in_left(in_left), .in_right(in_right),
    .att_write(att_write), .att_sel(att_sel), .att_value(att_value), .mute(mute),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Reference model: gains/targets indexed LL=0, LR=1, RL=2, RR=3.
  int  g[4], t[4];
  bit  m_mute;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    g = '{128, 0, 0, 128};
    t = '{128, 0, 0, 128};
  endtask

  task automatic model_write(input int sel, input int v);
    t[sel] = (v > 128) ? 128 : v;
  endtask

  task automatic model_sample(input int l, input int r, output int el, output int er);
    int eff;
    el = sat((l * g[0] + r * g[2]) >>> 7);
    er = sat((l * g[1] + r * g[3]) >>> 7);
    for (int i = 0; i < 4; i++) begin
      eff = m_mute ? 0 : t[i];
      if (g[i] < eff) g[i]++;
      else if (g[i] > eff) g[i]--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int sel, input int v);
    att_sel   = 2'(sel);
    att_value = 8'(v);
    att_write = 1'b1;
    tick();
    att_write = 1'b0;
    model_write(sel, v);
  endtask

  task automatic set_mute(input bit m);
    mute   = m;
    m_mute = m;
  endtask

  // One strobe from idle; optionally a gain write timed onto the output cycle.
  task automatic send(input int l, input int r, output int ol, output int orr,
                      input bit wr = 1'b0, input int ws = 0, input int wv = 0);
    int n, el, er;
    in_left       = 16'(l);
    in_right      = 16'(r);
    sample_strobe = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      sample_strobe = 1'b0;
      att_write     = 1'b0;
      if (wr && n == 5) begin
        att_sel   = 2'(ws);
        att_value = 8'(wv);
        att_write = 1'b1;
      end
    end while (!out_valid && n < 20);
    att_write = 1'b0;
    chk("latency", n, 6);
    model_sample(l, r, el, er);
    if (wr) model_write(ws, wv);
    ol  = int'(out_left);
    orr = int'(out_right);
    chk("out_left", ol, el);
    chk("out_right", orr, er);
  endtask

  // Strobes spaced 'gap' cycles apart while the first sample is still in flight.
  task automatic burst(input int nstr, input int gap);
    int lv[3], rv[3], el, er;
    int tq[$], lq[$], rq[$];
    for (int k = 0; k < 3; k++) begin
      lv[k] = int'($urandom_range(0, 65535)) - 32768;
      rv[k] = int'($urandom_range(0, 65535)) - 32768;
    end
    for (int c = 0; c < 30; c++) begin
      sample_strobe = 1'b0;
      for (int k = 0; k < nstr; k++)
        if (c == k * gap) begin
          sample_strobe = 1'b1;
          in_left  = 16'(lv[k]);
          in_right = 16'(rv[k]);
        end
      tick();
      if (out_valid) begin
        tq.push_back(c + 1);
        lq.push_back(int'(out_left));
        rq.push_back(int'(out_right));
      end
    end
    sample_strobe = 1'b0;
    chk("burst_count", tq.size(), 2);
    for (int i = 0; i < 2; i++) begin
      model_sample(lv[i], rv[i], el, er);
      if (i < tq.size()) begin
        chk("burst_time", tq[i], 6 * (i + 1));
        chk("burst_left", lq[i], el);
        chk("burst_right", rq[i], er);
      end
    end
    chk("burst_overrun", overrun, (nstr > 2) ? 1 : 0);
  endtask

  initial begin
    int ol, orr, cnt;
    reset_n = 1'b0; sample_strobe = 1'b0; att_write = 1'b0; att_sel = 2'd0;
    att_value = 8'd0; in_left = '0; in_right = '0;
    set_mute(1'b0);
    model_reset();
    repeat (3) tick();
    chk("rst_out_left", out_left, 0);
    chk("rst_out_right", out_right, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    tick();

    send(1000, -2000, ol, orr);
    chk("straight_l", ol, 1000);
    chk("straight_r", orr, -2000);

    // Ramp LL from unity down to half.
    do_write(0, 8'h40);
    for (int k = 1; k <= 66; k++) begin
      send(16'h4000, 0, ol, orr);
      if (k == 1)  chk("ramp_first", ol, 16'h4000);
      if (k >= 65) chk("ramp_settled", ol, 16'h2000);
    end

    // A write coinciding with the output step must not affect that step.
    send(16'h4000, 0, ol, orr, 1'b1, 0, 0);
    send(16'h4000, 0, ol, orr);
    chk("wr_at_out_old_tgt", ol, 16'h2000);
    send(16'h4000, 0, ol, orr);
    chk("wr_at_out_new_tgt", ol, 16'h1F80);

    // All gains to unity (with clamping and last-write-wins), then saturate.
    do_write(0, 8'hFF);
    do_write(1, 8'h80);
    do_write(2, 8'h90);
    do_write(3, 8'h10);
    do_write(3, 8'h80);
    for (int k = 0; k < 130; k++) send(0, 0, ol, orr);
    send(30000, 30000, ol, orr);
    chk("sat_pos_l", ol, 32767);
    chk("sat_pos_r", orr, 32767);
    send(-30000, -30000, ol, orr);
    chk("sat_neg_l", ol, -32768);
    chk("sat_neg_r", orr, -32768);

    set_mute(1'b1);
    for (int k = 0; k < 129; k++) send(20000, -15000, ol, orr);
    chk("mute_l", ol, 0);
    chk("mute_r", orr, 0);
    set_mute(1'b0);
    for (int k = 0; k < 128; k++) send(int'($urandom_range(0, 4000)) - 2000, 0, ol, orr);
    send(1000, 0, ol, orr);
    chk("unmute_l", ol, 1000);
    chk("unmute_r", orr, 1000);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 3)
        repeat ($urandom_range(1, 2)) do_write($urandom_range(0, 3), $urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) set_mute(~m_mute);
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, ol, orr);
      repeat ($urandom_range(0, 3)) tick();
    end
    set_mute(1'b0);

    burst(2, 2);
    burst(3, 1);

    // Reset while the third multiply cycle is underway.
    in_left = 16'sd1234; in_right = 16'sd4321;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_left", out_left, 0);
    chk("midrst_right", out_right, 0);
    chk("midrst_overrun", overrun, 0);
    model_reset();
    cnt = 0;
    repeat (3) begin tick(); cnt += int'(out_valid); end
    reset_n = 1'b1;
    repeat (10) begin tick(); cnt += int'(out_valid); end
    chk("midrst_no_valid", cnt, 0);
    send(1000, -2000, ol, orr);
    chk("postrst_l", ol, 1000);
    chk("postrst_r", orr, -2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
